tinyspu_host_driver: RTL and testbench

Host-side command sequencer for the tiny SPU: accepts queued command words, drives the SPU's `{Op,Q}` command byte and data byte at the right cycles, waits out the SPU's register latency, and captures the `{M,N}` result byte into a valid/ready result port. It sits between a host controller (or test sequencer) and the SPU pin interface. It is the initiator side of the SPU command/result protocol.

---
 rtl/tinyspu_host_driver.sv | 158 +++++++++++++++
 tb/tb_tinyspu_host_driver.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyspu_host_driver.sv
// Host-side command sequencer for the tiny SPU: queues command words, issues {Op,Q}/uio, captures {M,N}.
// Define TINYSPU_DRV_FIFO_EN for a CMD_DEPTH-entry command FIFO; otherwise a single holding register is used.
//
// state   | meaning
// IDLE    | nothing issuing; SPU pins at idle values
// ISSUE   | one cycle driving {Op,Q}/uio with ena=1
// WAIT    | ena low while the SPU result settles (RESULT_LAT-1 cycles)
// CAPTURE | {M,N} sampled into the result buffer at the end of this cycle
module tinyspu_host_driver #(
  parameter int RESULT_LAT = 2,
  parameter int CMD_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [16:0] cmd_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic [7:0]  spu_ui,
  output logic [7:0]  spu_uio,
  output logic        spu_ena,
  input  logic [7:0]  spu_uo,
  output logic        busy
);

  if (RESULT_LAT < 2) begin : g_bad_lat
    $error("RESULT_LAT must be at least 2");
  end
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  localparam int WW = (RESULT_LAT > 2) ? $clog2(RESULT_LAT) : 1;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          cur_cap;

  logic        empty, head_valid, accept, bypass, push, pop, store_empty_nxt;
  logic [16:0] head;
  logic        cap_done, buf_ok, slot_open, issue_now, go_idle;

  // An empty store lets the offered command go straight to ISSUE in the accepting cycle.
  assign head_valid = !empty || cmd_valid;
  assign accept     = cmd_valid && cmd_ready;
  assign cap_done   = (state == CAPTURE) && (!res_valid || res_ready);
  // In CAPTURE the buffer is about to be refilled, so a capture command needs the consumer ready now.
  assign buf_ok     = (state == CAPTURE) ? res_ready : (!res_valid || res_ready);
  assign slot_open  = (state == IDLE) || (state == ISSUE && !cur_cap) || cap_done;
  assign issue_now  = slot_open && head_valid && (!head[16] || buf_ok);
  assign go_idle    = slot_open && !issue_now;
  assign bypass     = empty && issue_now;
  assign push       = accept && !bypass;
  assign pop        = !empty && issue_now;

`ifdef TINYSPU_DRV_FIFO_EN
  localparam int AW = $clog2(CMD_DEPTH);

  logic [16:0] mem [CMD_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic        full;

  assign empty           = (wr_ptr == rd_ptr);
  assign full            = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready       = !reset && !full;
  assign head            = empty ? cmd_data : mem[rd_ptr[AW-1:0]];
  assign wr_ptr_nxt      = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt      = rd_ptr + {{AW{1'b0}}, pop};
  assign store_empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_data;
  end
`else
  logic        hold_valid;
  logic [16:0] hold_data;

  assign empty           = !hold_valid;
  assign cmd_ready       = !reset && (!hold_valid || pop);
  assign head            = hold_valid ? hold_data : cmd_data;
  assign store_empty_nxt = !(push || (hold_valid && !pop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      hold_valid <= push || (hold_valid && !pop);
      if (push) hold_data <= cmd_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cur_cap   <= 1'b0;
      spu_ui    <= '0;
      spu_uio   <= '0;
      spu_ena   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      spu_ena <= 1'b0;
      spu_ui  <= '0;
      spu_uio <= '0;
      busy    <= !go_idle || !store_empty_nxt;
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (issue_now) begin
        spu_ena <= 1'b1;
        spu_ui  <= head[15:8];
        spu_uio <= head[7:0];
        cur_cap <= head[16];
      end
      unique case (state)
        IDLE: if (issue_now) state <= ISSUE;
        ISSUE: begin
          if (cur_cap) begin
            state    <= WAIT;
            wait_cnt <= WW'(RESULT_LAT - 2);
          end else if (!issue_now) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CAPTURE;
          else wait_cnt <= wait_cnt - 1'b1;
        end
        CAPTURE: begin
          // ena stays low, so {M,N} is stable while a full buffer holds us here.
          if (cap_done) begin
            res_data  <= spu_uo;
            res_valid <= 1'b1;
            state     <= issue_now ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyspu_host_driver.sv
// Self-checking bench for tinyspu_host_driver against a small behavioural SPU stand-in.
module tb_tinyspu_host_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, res_valid, res_ready, spu_ena, busy;
  logic [16:0] cmd_data;
  logic [7:0]  res_data, spu_ui, spu_uio, spu_uo;

  logic        cmd_valid3, cmd_ready3, res_valid3, res_ready3, spu_ena3, busy3;
  logic [16:0] cmd_data3;
  logic [7:0]  res_data3, spu_ui3, spu_uio3, spu_uo3;

  always #5 clk = ~clk;

  tinyspu_host_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .spu_ui(spu_ui),
    .spu_uio(spu_uio), .spu_ena(spu_ena), .spu_uo(spu_uo), .busy(busy)
  );

  tinyspu_host_driver #(.RESULT_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3), .spu_ui(spu_ui3),
    .spu_uio(spu_uio3), .spu_ena(spu_ena3), .spu_uo(spu_uo3), .busy(busy3)
  );

  // SPU stand-in: Op 3 = ZeroMN, Op 1 = all ones, otherwise uio ^ {Q,Op}.
  function automatic logic [7:0] spu_fn(input logic [3:0] op, input logic [3:0] q, input logic [7:0] uio);
    case (op)
      4'h3:    return 8'h00;
      4'h1:    return 8'hFF;
      default: return uio ^ {q, op};
    endcase
  endfunction

  logic [3:0] m_op = '0, m_q = '0, m3_op = '0, m3_q = '0;
  logic [7:0] m_uio = '0, m3_uio = '0, m3_pad = '0;

  always @(posedge clk) begin
    if (spu_ena) begin
      m_op  <= spu_ui[7:4];
      m_q   <= spu_ui[3:0];
      m_uio <= spu_uio;
    end
    if (spu_ena3) begin
      m3_op  <= spu_ui3[7:4];
      m3_q   <= spu_ui3[3:0];
      m3_uio <= spu_uio3;
    end
    m3_pad <= spu_fn(m3_op, m3_q, m3_uio);
  end

  assign spu_uo  = spu_fn(m_op, m_q, m_uio);
  assign spu_uo3 = m3_pad;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [16:0] cmd;
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic [7:0]  res;
  } vec_t;

  vec_t        vecs [4];
  logic [16:0] full_cmd [6];
  logic [7:0]  full_exp [6];
  logic [7:0]  b2b [4];
  logic [7:0]  got [6];
  int          iss [8];

`ifdef TINYSPU_DRV_FIFO_EN
  localparam int EXP_CAP = 5;
`else
  localparam int EXP_CAP = 2;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, acc, ng, ni;
    logic rdy;

    vecs[0] = '{17'h13635, 8'h36, 8'h35, 8'h00};
    vecs[1] = '{17'h11000, 8'h10, 8'h00, 8'hFF};
    vecs[2] = '{17'h15A0F, 8'h5A, 8'h0F, 8'hAA};
    vecs[3] = '{17'h12310, 8'h23, 8'h10, 8'h22};
    full_cmd = '{17'h15100, 17'h16201, 17'h17302, 17'h110AA, 17'h13F77, 17'h144F0};
    full_exp = '{8'h15, 8'h27, 8'h35, 8'hFF, 8'h00, 8'hB4};
    b2b      = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; res_ready = 1'b0;
    cmd_valid3 = 1'b0; cmd_data3 = '0; res_ready3 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_spu_ena", 32'(spu_ena), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    step();
    chk("post_rst_busy", 32'(busy), 0);

    // Single captures, one per table entry.
    for (int i = 0; i < 4; i++) begin
      cmd_data = vecs[i].cmd;
      cmd_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 1);
      step();
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_e0_ena", i), 32'(spu_ena), 1);
      chk($sformatf("v%0d_e0_ui", i), 32'(spu_ui), 32'(vecs[i].ui));
      chk($sformatf("v%0d_e0_uio", i), 32'(spu_uio), 32'(vecs[i].uio));
      chk($sformatf("v%0d_e0_busy", i), 32'(busy), 1);
      step();
      chk($sformatf("v%0d_e1_ena", i), 32'(spu_ena), 0);
      chk($sformatf("v%0d_e1_ui", i), 32'({spu_ui, spu_uio}), 0);
      chk($sformatf("v%0d_e1_rv", i), 32'(res_valid), 0);
      step();
      chk($sformatf("v%0d_e2_rv", i), 32'(res_valid), 0);
      step();
      chk($sformatf("v%0d_e3_rv", i), 32'(res_valid), 1);
      chk($sformatf("v%0d_e3_data", i), 32'(res_data), 32'(vecs[i].res));
      chk($sformatf("v%0d_e3_busy", i), 32'(busy), 0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk($sformatf("v%0d_pop_rv", i), 32'(res_valid), 0);
      chk($sformatf("v%0d_pop_hold", i), 32'(res_data), 32'(vecs[i].res));
    end

    // Back-to-back non-capture loads.
    for (int i = 0; i < 4; i++) begin
      cmd_data = {1'b0, 4'h2, 4'h6, b2b[i]};
      cmd_valid = 1'b1;
      #1;
      chk($sformatf("b2b%0d_ready", i), 32'(cmd_ready), 1);
      step();
      chk($sformatf("b2b%0d_ena", i), 32'(spu_ena), 1);
      chk($sformatf("b2b%0d_ui", i), 32'(spu_ui), 'h26);
      chk($sformatf("b2b%0d_uio", i), 32'(spu_uio), 32'(b2b[i]));
      chk($sformatf("b2b%0d_rv", i), 32'(res_valid), 0);
    end
    cmd_valid = 1'b0;
    step();
    chk("b2b_end_ena", 32'(spu_ena), 0);
    chk("b2b_end_rv", 32'(res_valid), 0);
    chk("b2b_end_busy", 32'(busy), 0);

    // Backpressure: the second capture waits for the first result to transfer.
    cmd_data = vecs[2].cmd;
    cmd_valid = 1'b1;
    step();
    cmd_data = vecs[3].cmd;
    #1;
    chk("bp_second_ready", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("bp_first_rv", 32'(res_valid), 1);
    chk("bp_first_data", 32'(res_data), 'hAA);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("bp_hold%0d_ena", i), 32'(spu_ena), 0);
      chk($sformatf("bp_hold%0d_data", i), 32'(res_data), 'hAA);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_issue_ena", 32'(spu_ena), 1);
    chk("bp_issue_ui", 32'(spu_ui), 'h23);
    chk("bp_issue_rv", 32'(res_valid), 0);
    chk("bp_issue_hold", 32'(res_data), 'hAA);
    k = 0;
    while (!res_valid && k < 10) begin
      step();
      k++;
    end
    chk("bp_second_lat", 32'(k), 3);
    chk("bp_second_data", 32'(res_data), 'h22);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset asserted while waiting on a result.
    cmd_data = vecs[2].cmd;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rmid_e0_ena", 32'(spu_ena), 1);
    step();
    chk("rmid_wait_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("rmid_ui", 32'(spu_ui), 0);
    chk("rmid_uio", 32'(spu_uio), 0);
    chk("rmid_ena", 32'(spu_ena), 0);
    chk("rmid_rv", 32'(res_valid), 0);
    chk("rmid_data", 32'(res_data), 0);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_cmd_ready", 32'(cmd_ready), 0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rmid_after%0d_rv", i), 32'(res_valid), 0);
      chk($sformatf("rmid_after%0d_ena", i), 32'(spu_ena), 0);
    end
    chk("rmid_after_ready", 32'(cmd_ready), 1);
    chk("rmid_after_busy", 32'(busy), 0);

    // Fill the command store with res_ready low, then drain in order.
    acc = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 6) begin
        cmd_data = full_cmd[acc];
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      rdy = cmd_ready;
      step();
      if (rdy && cmd_valid) acc++;
    end
    chk("full_accepted", 32'(acc), 32'(EXP_CAP));
    chk("full_cmd_ready", 32'(cmd_ready), 0);
    chk("full_first_data", 32'(res_data), 32'(full_exp[0]));

    ng = 0;
    ni = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 100 && ng < 6; c++) begin
      if (acc < 6) begin
        cmd_data = full_cmd[acc];
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      rdy = cmd_ready;
      if (res_valid) begin
        got[ng] = res_data;
        ng++;
      end
      if (spu_ena && ni < 8) begin
        iss[ni] = c;
        ni++;
      end
      if (ng < 6) begin
        step();
        if (rdy && cmd_valid) acc++;
      end
    end
    cmd_valid = 1'b0;
    chk("drain_count", 32'(ng), 6);
    for (int i = 0; i < ng; i++) chk($sformatf("drain%0d_data", i), 32'(got[i]), 32'(full_exp[i]));
    chk("drain_issues", 32'(ni), 5);
    for (int i = 0; i + 1 < ni; i++) chk($sformatf("drain_gap%0d", i), 32'(iss[i+1] - iss[i]), 3);
    step();
    res_ready = 1'b0;
    chk("drain_end_rv", 32'(res_valid), 0);
    chk("drain_end_busy", 32'(busy), 0);

    // RESULT_LAT = 3 instance with one pad stage on the SPU output.
    cmd_data3 = vecs[2].cmd;
    cmd_valid3 = 1'b1;
    #1;
    chk("lat3_ready", 32'(cmd_ready3), 1);
    step();
    cmd_valid3 = 1'b0;
    chk("lat3_e0_ena", 32'(spu_ena3), 1);
    step();
    step();
    step();
    chk("lat3_e3_rv", 32'(res_valid3), 0);
    step();
    chk("lat3_e4_rv", 32'(res_valid3), 1);
    chk("lat3_e4_data", 32'(res_data3), 'hAA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
